store_buffer: RTL and testbench
===============================

# store_buffer

Posted store buffer between the single-cycle core's store path and `data_mem`. Accepts SB/SH/SW requests in one cycle, queues them in a DEPTH-entry FIFO, and drains one entry per cycle to `data_mem` whenever the core is not issuing a load. Load-to-store forwarding, or a load stall, keeps loads coherent with stores still in the buffer.

## Interface
- DATA_WIDTH, 32, data word width; fixed at 32.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  core presents a store this cycle.
- st_ready  out  1  buffer can accept; equals `count < DEPTH`.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data, right-aligned (rs2).
- st_funct3  in  3  000 SB, 001 SH, 010 SW.
- st_err  out  1  one-cycle pulse: accepted store had an illegal funct3 and was discarded.
- ld_req  in  1  core is performing a load this cycle; mutually exclusive with st_valid.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_funct3  in  3  load funct3, passed through to memory.
- ld_stall  out  1  core must hold the load.
- fwd_mask  out  4  bytes of the load word supplied by the buffer.
- fwd_data  out  DATA_WIDTH  forwarded bytes, in word lane positions.
- mem_wr_en, mem_addr, mem_wr_data, mem_funct3  out  1/ADDR_WIDTH/DATA_WIDTH/3  drive `data_mem`.
- empty  out  1  `count == 0`; used by fence.

## Operation
- Enqueue:
  - Fires when `st_valid && st_ready` at posedge.
  - Legal funct3: writes entry {addr, funct3, data, byte mask}.
  - Illegal funct3: no entry is written, and st_err is set for one cycle.
- Data replication at enqueue:
  - SB stores `{4{d[7:0]}}`.
  - SH stores `{2{d[15:0]}}`, so both half-lane write paths of `data_mem` see the correct bits.
  - SW stores the data unchanged.
- Byte mask:
  - SB: `1 << addr[1:0]`.
  - SH: `addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `4'b1111`.
  - Misaligned SH/SW are not checked; the lanes are taken from the address bits as above.
- Memory port mux:
  - `ld_req=1`: mem_addr=ld_addr, mem_funct3=ld_funct3, mem_wr_en=0.
  - Otherwise: drive the head entry, with `mem_wr_en = !empty`.
- Dequeue: the head pops at posedge when `mem_wr_en=1`.
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
- No bypass: a store accepted in cycle N drains no earlier than cycle N+1.
- Forwarding (see Configuration):
  - Match is on word address (`addr[ADDR_WIDTH-1:2]`).
  - Walk oldest to youngest; the youngest writer of each byte wins.
  - fwd_mask is the OR of matching entries' masks.
  - ld_stall=1 iff a match exists but the load's needed bytes are not fully covered by fwd_mask. Needed bytes use the load mask rules, with 100 treated as 000 and 101 as 001.
  - The core merges `fwd_mask ? fwd_data : rd_data_mem` per byte before extension.
- Full: st_ready=0, and the core holds st_valid. A drain that cycle frees a slot for the next cycle only.
- Reset mid-operation: all entries are discarded; pending stores are lost by definition.

## Timing
- Reset values: st_ready=1, empty=1, st_err=0, ld_stall=0, fwd_mask=0, fwd_data=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_funct3=0.
- count, pointers and st_err are registered.
- st_ready, empty, mem_* and the forwarding outputs are combinational from registered state plus ld_* inputs; zero-cycle lookup.
- Store-to-memory latency: 1 cycle minimum, plus 1 cycle per older entry, plus 1 cycle per intervening ld_req cycle.
- A stalled load stays stalled until the matching entries drain. Drain is blocked while ld_req=1, so the core must drop ld_req during a stall; ld_stall alone does not guarantee progress.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - Forwarding as above.
  - ld_stall only on partial coverage.
- STORE_BUFFER_FWD_EN undefined:
  - fwd_mask=0 and fwd_data=0 always.
  - ld_stall=1 whenever any entry matches the load word address.
  - No merge logic is synthesised.

## Structure
- Package `store_buffer_pkg`:
  - Funct3 constants F3_SB, F3_SH, F3_SW, F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Function `byte_mask(funct3, addr_lo)`.
  - Entry struct/field widths.
- Sub-module `sb_fifo`:
  - Storage array, rd/wr pointers and count.
  - Exposes all entries for the forwarding scan.
- Top level holds replication, port mux, forwarding and st_err.

## Test plan
- Reset with the FIFO full → empty=1, st_ready=1, mem_wr_en=0 the cycle after reset deasserts.
- SW 0xDEADBEEF to addr 0x10, ld_req held low → mem_wr_en=1, mem_addr=0x10, mem_wr_data=0xDEADBEEF one cycle later; empty after.
- SB 0xAB to 0x21, SH 0x1234 to 0x22, with ld_req held high → mem_wr_data is 0xABABABAB, then 0x12341234 when ld_req drops. A later LW at 0x20 reads 0x1234AB?? (byte 0 from prior contents).
- Four SW with ld_req=1 throughout → st_ready=0 on the fifth; st_ready=1 one cycle after ld_req drops.
- With FWD_EN: SW 0x11223344 to 0x40, then SB 0x55 to 0x41, then LW 0x40 → fwd_mask=1111, fwd_data=0x11225544, ld_stall=0. With LB 0x48: no match, ld_stall=0.
- Without FWD_EN: the same sequence → ld_stall=1 and fwd_mask=0 until both entries drain. An illegal funct3 011 store → st_err pulses and count is unchanged.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared constants, entry layout and lane helpers for the
// posted store buffer.
package store_buffer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sb_entry_t;

  // Byte lanes touched by an access; zero means the funct3 is not a legal store.
  function automatic logic [MASK_W-1:0] byte_mask(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo);
    case (funct3)
      F3_SB:   byte_mask = 4'b0001 << addr_lo;
      F3_SH:   byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

  // Spread right-aligned store data over every lane it may be written to.
  function automatic logic [DATA_W-1:0] replicate(input logic [2:0]        funct3,
                                                  input logic [DATA_W-1:0] data);
    case (funct3)
      F3_SB:   replicate = {4{data[7:0]}};
      F3_SH:   replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: entry storage, read/write pointers and occupancy count for the
// store buffer. All slots are visible so the top can scan them for loads.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  sb_entry_t        wr_entry,
  output sb_entry_t        entries [DEPTH],
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr;

  // Slot writes and pointer advance; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= wr_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted store queue between the core store path and data_mem.
// Build option: define STORE_BUFFER_FWD_EN to enable load-to-store forwarding;
// without it, any load hitting a buffered word simply stalls.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_err,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  ld_stall,
  output logic [3:0]            fwd_mask,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_funct3,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  sb_entry_t         entries [DEPTH];
  sb_entry_t         wr_entry;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  slot;
  logic [CNT_W-1:0]  count;
  logic [MASK_W-1:0] st_mask;
  logic              st_accept;
  logic              push;
  logic              hit;
  logic [ADDR_W-1:0] ld_addr_w;

  assign st_ready  = count < CNT_W'(DEPTH);
  assign empty     = count == '0;
  assign st_mask   = byte_mask(st_funct3, st_addr[1:0]);
  assign st_accept = st_valid && st_ready;
  assign push      = st_accept && (st_mask != '0);
  assign ld_addr_w = ADDR_W'(ld_addr);

  assign wr_entry = '{addr:   ADDR_W'(st_addr),
                      funct3: st_funct3,
                      data:   replicate(st_funct3, DATA_W'(st_data)),
                      mask:   st_mask};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (mem_wr_en),
    .wr_entry (wr_entry),
    .entries  (entries),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  // Illegal-funct3 store flag, raised for the cycle after the discarded store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_err <= 1'b0;
    else       st_err <= st_accept && (st_mask == '0);
  end

  // Memory port: loads own the port, otherwise the head entry drains.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = ADDR_WIDTH'(entries[rd_ptr].addr);
    mem_wr_data = DATA_WIDTH'(entries[rd_ptr].data);
    mem_funct3  = entries[rd_ptr].funct3;
    if (ld_req) begin
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end else begin
      mem_wr_en = !empty;
    end
  end

  // Oldest-to-youngest word-address scan; later matches overwrite earlier bytes.
  always_comb begin
    hit      = 1'b0;
    slot     = '0;
    fwd_mask = '0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) &&
          (entries[slot].addr[ADDR_W-1:2] == ld_addr_w[ADDR_W-1:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_mask = fwd_mask | entries[slot].mask;
        for (int b = 0; b < 4; b++) begin
          if (entries[slot].mask[b]) fwd_data[8*b +: 8] = entries[slot].data[8*b +: 8];
        end
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [MASK_W-1:0] ld_need;

  // Unsigned loads need the same lanes as their signed forms.
  assign ld_need  = byte_mask({1'b0, ld_funct3[1:0]}, ld_addr[1:0]);
  assign ld_stall = hit && ((ld_need & ~fwd_mask) != '0);
`else
  assign ld_stall = hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic, checked against
// a queue-based model of the buffer and a byte-addressed model of data_mem.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_err;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_stall;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct3;
  logic        empty;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_funct3   (st_funct3),
    .st_err      (st_err),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_funct3   (ld_funct3),
    .ld_stall    (ld_stall),
    .fwd_mask    (fwd_mask),
    .fwd_data    (fwd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_funct3  (mem_funct3),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
  } st_t;

  st_t        q[$];
  logic [7:0] mem_model [logic [31:0]];
  logic       exp_err;
  logic       do_acc, do_legal, do_pop;
  int         n_checks;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] tb_mask(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'd0:    return 4'b0001 << lo;
      3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] tb_need(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'd0, 3'd4: return 4'b0001 << lo;
      3'd1, 3'd5: return lo[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] tb_repl(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return {4{d[7:0]}};
      3'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Drive one cycle's inputs at negedge, then check every combinational output.
  task automatic drive_and_check(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic [2:0] sf, input logic lr, input logic [31:0] la,
                                 input logic [2:0] lf);
    logic [3:0]  em, m, need;
    logic [31:0] ed, rd;
    logic        hit, found, exp_stall;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_req = lr; ld_addr = la; ld_funct3 = lf;
    #1;
    check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("st_err", 32'(st_err), 32'(exp_err));
    check("mem_wr_en", 32'(mem_wr_en), 32'(!lr && q.size() > 0));
    if (lr) begin
      check("mem_addr_ld", mem_addr, la);
      check("mem_funct3_ld", 32'(mem_funct3), 32'(lf));
    end else if (q.size() > 0) begin
      check("mem_addr_st", mem_addr, q[0].addr);
      check("mem_funct3_st", 32'(mem_funct3), 32'(q[0].f3));
      check("mem_wr_data", mem_wr_data, tb_repl(q[0].f3, q[0].data));
    end
    // Per byte lane, the youngest buffered writer of that lane supplies it.
    hit = 1'b0; em = '0; ed = '0;
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) hit = 1'b1;
    for (int b = 0; b < 4; b++) begin
      found = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        m  = tb_mask(q[i].f3, q[i].addr[1:0]);
        rd = tb_repl(q[i].f3, q[i].data);
        if (!found && q[i].addr[31:2] == la[31:2] && m[b]) begin
          found = 1'b1; em[b] = 1'b1; ed[8*b +: 8] = rd[8*b +: 8];
        end
      end
    end
    need = tb_need(lf, la[1:0]);
`ifdef STORE_BUFFER_FWD_EN
    exp_stall = hit && ((need & ~em) != 4'b0000);
`else
    exp_stall = hit;
    em = '0; ed = '0;
`endif
    check("ld_stall", 32'(ld_stall), 32'(exp_stall));
    check("fwd_mask", 32'(fwd_mask), 32'(em));
    check("fwd_data", fwd_data, ed);
    do_acc   = sv && q.size() < DEPTH;
    do_legal = sf < 3'd3;
    do_pop   = !lr && q.size() > 0;
  endtask

  // Advance the clock and apply the cycle's enqueue/drain to the models.
  task automatic commit();
    logic [3:0]  m;
    logic [31:0] rd;
    @(posedge clk);
    if (do_pop) begin
      m  = tb_mask(q[0].f3, q[0].addr[1:0]);
      rd = tb_repl(q[0].f3, q[0].data);
      for (int b = 0; b < 4; b++)
        if (m[b]) mem_model[{q[0].addr[31:2], 2'(b)}] = rd[8*b +: 8];
      void'(q.pop_front());
    end
    if (do_acc && do_legal) q.push_back('{addr: st_addr, f3: st_funct3, data: st_data});
    exp_err = do_acc && !do_legal;
  endtask

  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] sf, input logic lr, input logic [31:0] la,
                      input logic [2:0] lf);
    drive_and_check(sv, sa, sd, sf, lr, la, lf);
    commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0, 3'd2);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; st_valid = 1'b0; ld_req = 1'b0;
    #1;
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_st_err", 32'(st_err), 32'd0);
    check("rst_ld_stall", 32'(ld_stall), 32'd0);
    check("rst_fwd_mask", 32'(fwd_mask), 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr_data", mem_wr_data, 32'd0);
    check("rst_mem_funct3", 32'(mem_funct3), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_err = 1'b0;
  endtask

  logic [31:0] ra, rdat, la_r;
  logic [2:0]  rf, lf_r;
  logic [2:0]  lfs [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int          sel;

  initial begin
    n_checks = 0; n_fail = 0; exp_err = 1'b0;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_req = 1'b0; ld_addr = '0; ld_funct3 = '0;
    apply_reset();
    idle(1);

    // Fill with loads held high, then reset while full.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4*i), 32'(i), 3'd2, 1'b1, 32'h80, 3'd2);
    drive_and_check(1'b1, 32'h110, 32'h5, 3'd2, 1'b1, 32'h80, 3'd2);
    check("full_st_ready", 32'(st_ready), 32'd0);
    commit();
    apply_reset();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0, 3'd2);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
    commit();

    // Single SW drains one cycle later.
    step(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0, 3'd2);
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0, 3'd2);
    check("sw_wr_en", 32'(mem_wr_en), 32'd1);
    check("sw_addr", mem_addr, 32'h10);
    check("sw_data", mem_wr_data, 32'hDEADBEEF);
    commit();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0, 3'd2);
    check("sw_empty_after", 32'(empty), 32'd1);
    commit();

    // SB/SH queued behind loads, then drained in order.
    step(1'b1, 32'h21, 32'hAB, 3'd0, 1'b1, 32'h20, 3'd2);
    step(1'b1, 32'h22, 32'h1234, 3'd1, 1'b1, 32'h20, 3'd2);
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h20, 3'd2);
    check("sbsh_ld_stall", 32'(ld_stall), 32'd1);
`ifdef STORE_BUFFER_FWD_EN
    check("sbsh_fwd_mask", 32'(fwd_mask), 32'he);
    check("sbsh_fwd_hi", 32'(fwd_data[31:8]), 32'h1234AB);
`endif
    commit();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd2);
    check("sb_drain", mem_wr_data, 32'hABABABAB);
    commit();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd2);
    check("sh_drain", mem_wr_data, 32'h12341234);
    commit();
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h20, 3'd2);

    // Forwarding over two stores to the same word.
    step(1'b1, 32'h40, 32'h11223344, 3'd2, 1'b1, 32'h80, 3'd2);
    step(1'b1, 32'h41, 32'h55, 3'd0, 1'b1, 32'h80, 3'd2);
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h40, 3'd2);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_lw_mask", 32'(fwd_mask), 32'hf);
    check("fwd_lw_data", fwd_data, 32'h11225544);
    check("fwd_lw_stall", 32'(ld_stall), 32'd0);
`else
    check("nofwd_lw_stall", 32'(ld_stall), 32'd1);
    check("nofwd_lw_mask", 32'(fwd_mask), 32'd0);
`endif
    commit();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h48, 3'd0);
    check("lb_nomatch_stall", 32'(ld_stall), 32'd0);
    commit();
    idle(2);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h40, 3'd2);

    // Illegal funct3 store is discarded and flagged for one cycle.
    step(1'b1, 32'h50, 32'h77, 3'd3, 1'b0, 32'h0, 3'd2);
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd2);
    check("illegal_err", 32'(st_err), 32'd1);
    check("illegal_empty", 32'(empty), 32'd1);
    commit();
    drive_and_check(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd2);
    check("illegal_err_clr", 32'(st_err), 32'd0);
    commit();

    // Randomized traffic over a small address window to force overlaps.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      sel  = $urandom_range(0, 9);
      ra   = 32'h40 + 32'($urandom_range(0, 15));
      rdat = $urandom;
      rf   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      la_r = 32'h40 + 32'($urandom_range(0, 15));
      lf_r = lfs[$urandom_range(0, 4)];
      if (sel < 4)      step(1'b1, ra, rdat, rf, 1'b0, la_r, lf_r);
      else if (sel < 8) step(1'b0, ra, rdat, rf, 1'b1, la_r, lf_r);
      else              step(1'b0, ra, rdat, rf, 1'b0, la_r, lf_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
